pie_preamble_detect: RTL and testbench
======================================

Name: pie_preamble_detect

Overview:
- Tag-side receive-path block. Detects the reader-to-tag PIE preamble (delimiter, data-0, RTcal, TRcal) or frame-sync (delimiter, data-0, RTcal) on the demodulated envelope.
- Measures Tari, RTcal and TRcal in clk cycles.
- Classifies the frame and hands the calibration values to the command decoder and the backscatter timing logic.

Parameters:
- CNT_W, 10, width of interval counter and measurement outputs.
- DELIM_MIN, 8, minimum delimiter low time in cycles (inclusive).
- DELIM_MAX, 24, maximum delimiter low time in cycles (inclusive).

Ports:
- clk  in  1  receive clock.
- reset  in  1  asynchronous, active-high.
- demodin  in  1  demodulated envelope, asynchronous; 1 = CW, 0 = reader pulse.
- restart  in  1  synchronous; rearms the detector from DONE or ERR.
- tari  out  CNT_W  measured data-0 length.
- rtcal  out  CNT_W  measured RTcal length.
- trcal  out  CNT_W  measured TRcal length; 0 for frame-sync.
- is_preamble  out  1  1 = TRcal present (Query), 0 = frame-sync.
- firstbit  out  1  first data bit after a frame-sync; 0 for a preamble.
- done  out  1  measurements valid; held high until restart or reset.
- error  out  1  malformed sequence; held high until restart or reset.

Behaviour:
- Reset: all outputs 0, state IDLE, counter 0, synchronizer flops 1 (CW).
- Input path: demodin passes through a 2-flop synchronizer, then a third flop for edge detection.
  - rise = sync & ~prev; fall = ~sync & prev.
  - Edge latency is a constant 3 cycles, so measured intervals are unaffected.
- Counter cnt:
  - Cleared to 0 on the cycle an edge relevant to the current state is detected; otherwise increments by 1.
  - Saturates at all-ones; never wraps.
  - A captured interval equals the number of cycles between the two edges.
- States and transitions:
  - IDLE: on fall, clear cnt and go to DELIM.
  - DELIM: on rise, check cnt. If DELIM_MIN <= cnt <= DELIM_MAX, clear cnt and go to TARI. Otherwise return to IDLE silently (not an error). If cnt exceeds DELIM_MAX while low, go to IDLE.
  - TARI: on rise, tari <= cnt, clear cnt, go to RTCAL.
  - RTCAL: on rise, rtcal <= cnt, clear cnt.
    - If cnt <= tari, go to ERR.
    - Otherwise go to THIRD.
  - THIRD: on rise, compare cnt with rtcal.
    - cnt > rtcal: trcal <= cnt, is_preamble <= 1, firstbit <= 0.
    - Otherwise: trcal <= 0, is_preamble <= 0, firstbit <= (cnt > rtcal>>1).
    - Either way, done <= 1 the same cycle and go to DONE.
  - DONE / ERR: hold all outputs and ignore demodin. restart clears done, error and the measurement outputs and goes to IDLE next cycle.
- Falling edges inside TARI, RTCAL and THIRD are ignored; only rising edges delimit symbols.
- Saturation of cnt in TARI, RTCAL or THIRD goes to ERR with error <= 1 (reader dropped mid-frame).
- Measurements update only at their capture point and are stable while done=1.
- done and error are never both 1.
- Simultaneous restart and capturing rise in THIRD: restart wins; no done pulse.
- Asynchronous reset mid-frame: immediate return to the reset state.
- Comparisons are unsigned CNT_W-bit. rtcal>>1 is a logical shift.

Decomposition:
- Shared package: state encoding constants (IDLE, DELIM, TARI, RTCAL, THIRD, DONE, ERR) and default CNT_W/DELIM limits, reused by the command decoder.
- One natural sub-module: edge_sync (2-flop synchronizer plus rise/fall detect, reset to 1), reusable by other envelope consumers.

Test Plan:
- Preamble: CW, low 12, then symbol periods 12, 33, 60 (each ending in a 4-cycle low pulse) -> done=1, tari=12, rtcal=33, trcal=60, is_preamble=1, error=0.
- Frame-sync with data-1: low 12, then periods 12, 33, 24 -> done=1, is_preamble=0, trcal=0, firstbit=1 (24 > 16).
- Frame-sync with data-0: low 12, then periods 12, 33, 12 -> firstbit=0, done=1.
- Bad delimiter: low 4, then a valid-looking sequence -> stays IDLE; no done, no error. A following correct delimiter and preamble is then detected normally.
- RTcal <= Tari: low 12, then periods 20, 18 -> error=1, done=0. restart -> error clears; the next valid preamble gives done=1.
- Mid-frame dropout: valid delimiter and Tari, then demodin held high for 1024+ cycles -> error=1. Separately, assert reset during RTCAL -> all outputs 0 immediately.

Source files
------------

// File: rtl/pie_preamble_detect_pkg.sv
// PIE preamble detector shared definitions.
// FSM encoding and default limits, also used by the command decoder.
package pie_preamble_detect_pkg;

  localparam int PIE_CNT_W     = 10;
  localparam int PIE_DELIM_MIN = 8;
  localparam int PIE_DELIM_MAX = 24;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DELIM = 3'd1,
    ST_TARI  = 3'd2,
    ST_RTCAL = 3'd3,
    ST_THIRD = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } pie_state_e;

endpackage

// File: rtl/pie_preamble_detect_if.sv
// Envelope input, restart and calibration results of the PIE
// preamble detector.
interface pie_preamble_detect_if
  import pie_preamble_detect_pkg::*;
#(
  parameter int CNT_W = PIE_CNT_W
) ();

  logic             demodin;
  logic             restart;
  logic [CNT_W-1:0] tari;
  logic [CNT_W-1:0] rtcal;
  logic [CNT_W-1:0] trcal;
  logic             is_preamble;
  logic             firstbit;
  logic             done;
  logic             error;

  modport slave (
    input  demodin,
    input  restart,
    output tari,
    output rtcal,
    output trcal,
    output is_preamble,
    output firstbit,
    output done,
    output error
  );

  modport master (
    output demodin,
    output restart,
    input  tari,
    input  rtcal,
    input  trcal,
    input  is_preamble,
    input  firstbit,
    input  done,
    input  error
  );

endinterface

// File: rtl/pie_preamble_detect_edge_sync.sv
// Two-flop synchronizer plus edge detect for the demodulated envelope.
// Idles at 1 (CW) so reset never produces a spurious edge.
module pie_preamble_detect_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q;
  logic s2_q;
  logic prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~prev_q;
  assign fall_o = ~s2_q & prev_q;

endmodule

// File: rtl/pie_preamble_detect.sv
// PIE preamble / frame-sync detector: measures Tari, RTcal, TRcal
// between rising edges of the synchronized envelope.
module pie_preamble_detect
  import pie_preamble_detect_pkg::*;
#(
  parameter int CNT_W     = PIE_CNT_W,
  parameter int DELIM_MIN = PIE_DELIM_MIN,
  parameter int DELIM_MAX = PIE_DELIM_MAX
) (
  input logic                  clk,
  input logic                  reset,
  pie_preamble_detect_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] DMIN    = CNT_W'(DELIM_MIN);
  localparam logic [CNT_W-1:0] DMAX    = CNT_W'(DELIM_MAX);

  logic rise;
  logic fall;

  pie_preamble_detect_edge_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .d_i    (bus.demodin),
    .rise_o (rise),
    .fall_o (fall)
  );

  pie_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tari_q, tari_d;
  logic [CNT_W-1:0] rtcal_q, rtcal_d;
  logic [CNT_W-1:0] trcal_q, trcal_d;
  logic             pre_q, pre_d;
  logic             fb_q, fb_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             cnt_sat;
  logic [CNT_W-1:0] cnt_inc;

  // cnt_inc is the interval length as seen on the edge cycle itself
  assign cnt_sat = (cnt_q == CNT_MAX);
  assign cnt_inc = cnt_sat ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tari_q  <= '0;
      rtcal_q <= '0;
      trcal_q <= '0;
      pre_q   <= 1'b0;
      fb_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tari_q  <= tari_d;
      rtcal_q <= rtcal_d;
      trcal_q <= trcal_d;
      pre_q   <= pre_d;
      fb_q    <= fb_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    tari_d  = tari_q;
    rtcal_d = rtcal_q;
    trcal_d = trcal_q;
    pre_d   = pre_q;
    fb_d    = fb_q;
    done_d  = done_q;
    err_d   = err_q;

    // restart overrides any capture, including a rise in THIRD
    if (bus.restart) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      tari_d  = '0;
      rtcal_d = '0;
      trcal_d = '0;
      pre_d   = 1'b0;
      fb_d    = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (fall) begin
            cnt_d   = '0;
            state_d = ST_DELIM;
          end
        end
        ST_DELIM: begin
          if (rise) begin
            if (cnt_inc >= DMIN && cnt_inc <= DMAX) begin
              cnt_d   = '0;
              state_d = ST_TARI;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (cnt_inc > DMAX) begin
            state_d = ST_IDLE;
          end
        end
        ST_TARI: begin
          if (rise) begin
            tari_d  = cnt_inc;
            cnt_d   = '0;
            state_d = ST_RTCAL;
          end else if (cnt_sat) begin
            err_d   = 1'b1;
            state_d = ST_ERR;
          end
        end
        ST_RTCAL: begin
          if (rise) begin
            rtcal_d = cnt_inc;
            cnt_d   = '0;
            if (cnt_inc <= tari_q) begin
              err_d   = 1'b1;
              state_d = ST_ERR;
            end else begin
              state_d = ST_THIRD;
            end
          end else if (cnt_sat) begin
            err_d   = 1'b1;
            state_d = ST_ERR;
          end
        end
        ST_THIRD: begin
          if (rise) begin
            if (cnt_inc > rtcal_q) begin
              trcal_d = cnt_inc;
              pre_d   = 1'b1;
              fb_d    = 1'b0;
            end else begin
              trcal_d = '0;
              pre_d   = 1'b0;
              fb_d    = (cnt_inc > (rtcal_q >> 1));
            end
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else if (cnt_sat) begin
            err_d   = 1'b1;
            state_d = ST_ERR;
          end
        end
        ST_DONE, ST_ERR: begin
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.tari        = tari_q;
  assign bus.rtcal       = rtcal_q;
  assign bus.trcal       = trcal_q;
  assign bus.is_preamble = pre_q;
  assign bus.firstbit    = fb_q;
  assign bus.done        = done_q;
  assign bus.error       = err_q;

endmodule

// File: tb/tb_pie_preamble_detect.sv
// Directed bench for pie_preamble_detect with an interval-level
// reference model and a per-cycle output compare.
module tb_pie_preamble_detect;

  localparam int W = 10;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pie_preamble_detect_if #(.CNT_W(W)) bus ();

  pie_preamble_detect #(
    .CNT_W     (W),
    .DELIM_MIN (8),
    .DELIM_MAX (24)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  logic [W-1:0] e_tari, e_rtcal, e_trcal;
  logic         e_pre, e_fb, e_done, e_err;

  always @(negedge clk) begin
    total++;
    if (bus.done && bus.error) begin
      bad++;
      $display("FAIL excl t=%0t done=%b error=%b want not both",
               $time, bus.done, bus.error);
    end
    if (chk_en) begin
      total++;
      if ({bus.done, bus.error, bus.tari, bus.rtcal, bus.trcal,
           bus.is_preamble, bus.firstbit} !==
          {e_done, e_err, e_tari, e_rtcal, e_trcal, e_pre, e_fb}) begin
        bad++;
        $display("FAIL cyc t=%0t got d=%b e=%b ta=%0d rt=%0d tr=%0d p=%b f=%b want d=%b e=%b ta=%0d rt=%0d tr=%0d p=%b f=%b",
                 $time, bus.done, bus.error, bus.tari, bus.rtcal,
                 bus.trcal, bus.is_preamble, bus.firstbit,
                 e_done, e_err, e_tari, e_rtcal, e_trcal, e_pre, e_fb);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic v, input int n);
    bus.demodin = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic model_zero();
    e_tari = '0; e_rtcal = '0; e_trcal = '0;
    e_pre = 1'b0; e_fb = 1'b0; e_done = 1'b0; e_err = 1'b0;
  endtask

  // Outcome of a frame from its low-delimiter length and the
  // rise-to-rise periods that follow; n periods, then CW forever.
  task automatic model(input int d, input int p0, input int p1,
                       input int p2, input int n);
    model_zero();
    if (d >= 8 && d <= 24) begin
      e_tari = W'(p0);
      if (n < 2) e_err = 1'b1;
      else begin
        e_rtcal = W'(p1);
        if (p1 <= p0) e_err = 1'b1;
        else if (n < 3) e_err = 1'b1;
        else if (p2 > p1) begin
          e_trcal = W'(p2); e_pre = 1'b1; e_done = 1'b1;
        end else begin
          e_fb = (p2 > p1 / 2); e_done = 1'b1;
        end
      end
    end
  endtask

  task automatic send(input int d, input int p0, input int p1,
                      input int p2, input int n);
    int p[3];
    p = '{p0, p1, p2};
    drive(1'b0, d);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, p[i] - 4);
      drive(1'b0, 4);
    end
    bus.demodin = 1'b1;
  endtask

  task automatic frame(input int d, input int p0, input int p1,
                       input int p2, input int n);
    int k;
    chk_en = 1'b0;
    model(d, p0, p1, p2, n);
    send(d, p0, p1, p2, n);
    idle(8);
    if (e_done || e_err) begin
      k = 0;
      while (!(bus.done || bus.error) && k < 1500) begin
        @(negedge clk);
        k++;
      end
      total++;
      if (k >= 1500) begin
        bad++;
        $display("FAIL timeout d=%0d got done=%b error=%b want end",
                 d, bus.done, bus.error);
      end
      idle(2);
    end
    chk_en = 1'b1;
    idle(10);
  endtask

  task automatic do_restart();
    chk_en = 1'b0;
    bus.restart = 1'b1;
    @(negedge clk);
    bus.restart = 1'b0;
    model_zero();
    idle(2);
    chk_en = 1'b1;
    idle(3);
  endtask

  initial begin
    reset = 1'b1;
    bus.demodin = 1'b1;
    bus.restart = 1'b0;
    model_zero();
    idle(3);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_error", int'(bus.error), 0);
    chk("rst_tari", int'(bus.tari), 0);
    reset = 1'b0;
    chk_en = 1'b1;
    idle(5);

    frame(12, 12, 33, 60, 3);
    chk("pre_tari", int'(bus.tari), 12);
    chk("pre_rtcal", int'(bus.rtcal), 33);
    chk("pre_trcal", int'(bus.trcal), 60);
    chk("pre_is", int'(bus.is_preamble), 1);
    do_restart();

    frame(12, 12, 33, 24, 3);
    chk("fs1_fb", int'(bus.firstbit), 1);
    chk("fs1_trcal", int'(bus.trcal), 0);
    do_restart();

    frame(12, 12, 33, 12, 3);
    chk("fs0_fb", int'(bus.firstbit), 0);
    chk("fs0_done", int'(bus.done), 1);
    do_restart();

    frame(4, 12, 33, 60, 3);
    chk("baddl_done", int'(bus.done), 0);
    chk("baddl_err", int'(bus.error), 0);
    frame(12, 12, 33, 60, 3);
    chk("after_bad_done", int'(bus.done), 1);
    do_restart();

    frame(8, 10, 21, 40, 3);
    chk("dmin_trcal", int'(bus.trcal), 40);
    do_restart();
    frame(24, 10, 21, 15, 3);
    chk("dmax_fb", int'(bus.firstbit), 1);
    do_restart();
    frame(25, 10, 21, 40, 3);
    chk("d25_done", int'(bus.done), 0);
    frame(7, 10, 21, 40, 3);
    chk("d7_done", int'(bus.done), 0);

    frame(12, 20, 18, 0, 2);
    chk("rt_err", int'(bus.error), 1);
    chk("rt_done", int'(bus.done), 0);
    do_restart();
    chk("rs_err", int'(bus.error), 0);
    frame(12, 12, 33, 60, 3);
    chk("rs_done", int'(bus.done), 1);
    do_restart();

    frame(12, 12, 0, 0, 1);
    chk("drop_err", int'(bus.error), 1);
    do_restart();

    chk_en = 1'b0;
    send(12, 12, 0, 0, 1);
    idle(10);
    chk("arst_pre_tari", int'(bus.tari), 12);
    #2 reset = 1'b1;
    #1;
    chk("arst_tari", int'(bus.tari), 0);
    chk("arst_done", int'(bus.done), 0);
    chk("arst_err", int'(bus.error), 0);
    @(negedge clk);
    reset = 1'b0;
    model_zero();
    chk_en = 1'b1;
    idle(5);
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
